mul_iter: RTL

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
//
// Purpose:
//   Iterative radix-2 shift-add multiplier for RISC-V style MUL / MULH /
//   MULHSU / MULHU and their word (MULW) variants. The unit retires one
//   multiplier bit per clock, LSB first. A full-width operation takes WIDTH
//   edges and a word operation takes WIDTH/2 edges. The result is held until
//   the consumer accepts it.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_flush        synchronous abort; highest priority after reset
//   i_start        begin a multiply (accepted only while idle)
//   i_mulw         word op: low WIDTH/2 operand bits, sign-extended result
//   i_op           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_multiplicand rs1 operand
//   i_multiplier   rs2 operand
//   o_busy         iteration running or result waiting
//   o_end_valid    o_result is valid
//   i_end_ready    consumer accepts the result
//   o_result       product (zero whenever o_end_valid is low)
// -----------------------------------------------------------------------------
module mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic             i_mulw,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_multiplicand,
    input  logic [WIDTH-1:0] i_multiplier,
    output logic             o_busy,
    output logic             o_end_valid,
    input  logic             i_end_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mulOp_e;

    logic [CNT_W-1:0]   iterCount_q, iterCount_d;
    logic               endValid_q,  endValid_d;
    logic [2*WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [2*WIDTH-1:0] prod_q,      prod_d;
    logic               negate_q,    negate_d;
    mulOp_e             op_q,        op_d;
    logic               mulw_q,      mulw_d;

    logic [WIDTH-1:0]   opA, opB, magA, magB;
    logic               aSigned, bSigned, aNeg, bNeg;
    logic               accept;
    logic [2*WIDTH-1:0] signedProd;
    logic [WIDTH-1:0]   resultSel;

    // Operand conditioning: word ops sign-extend the low half first, then
    // each operand is reduced to a magnitude. Negating the most negative
    // value yields 100..0, which is the correct unsigned magnitude.
    always_comb begin
        opA = i_multiplicand;
        opB = i_multiplier;
        if (i_mulw) begin
            opA = {{HALF{i_multiplicand[HALF-1]}}, i_multiplicand[HALF-1:0]};
            opB = {{HALF{i_multiplier[HALF-1]}},   i_multiplier[HALF-1:0]};
        end
        aSigned = (i_op != OP_MULHU);
        bSigned = (i_op == OP_MUL) || (i_op == OP_MULH);
        aNeg    = aSigned && opA[WIDTH-1];
        bNeg    = bSigned && opB[WIDTH-1];
        magA    = aNeg ? -opA : opA;
        magB    = bNeg ? -opB : opB;
    end

    assign o_busy = (iterCount_q != '0) | endValid_q;
    assign accept = i_start && !o_busy;

    // Next-state logic. Flush wins over everything. A start is only seen
    // while idle, so a start in the same cycle that a result is accepted is
    // dropped because o_busy is still high on that edge.
    always_comb begin
        iterCount_d = iterCount_q;
        endValid_d  = endValid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        negate_d    = negate_q;
        op_d        = op_q;
        mulw_d      = mulw_q;

        if (i_flush) begin
            iterCount_d = '0;
            endValid_d  = 1'b0;
            mcand_d     = '0;
            mplier_d    = '0;
            prod_d      = '0;
            negate_d    = 1'b0;
            op_d        = OP_MUL;
            mulw_d      = 1'b0;
        end else if (accept) begin
            iterCount_d = i_mulw ? CNT_HALF : CNT_FULL;
            mcand_d     = {{WIDTH{1'b0}}, magA};
            mplier_d    = magB;
            prod_d      = '0;
            negate_d    = aNeg ^ bNeg;
            op_d        = mulOp_e'(i_op);
            mulw_d      = i_mulw;
        end else begin
            if (iterCount_q != '0) begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d     = mcand_q << 1;
                mplier_d    = mplier_q >> 1;
                iterCount_d = iterCount_q - CNT_ONE;
                if (iterCount_q == CNT_ONE) begin
                    endValid_d = 1'b1;
                end
            end
            if (endValid_q && i_end_ready) begin
                endValid_d = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            iterCount_q <= '0;
            endValid_q  <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            negate_q    <= 1'b0;
            op_q        <= OP_MUL;
            mulw_q      <= 1'b0;
        end else begin
            iterCount_q <= iterCount_d;
            endValid_q  <= endValid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            negate_q    <= negate_d;
            op_q        <= op_d;
            mulw_q      <= mulw_d;
        end
    end

    // Sign fix-up and result selection. Word ops always return the
    // sign-extended low half, whatever the captured op.
    always_comb begin
        signedProd = negate_q ? -prod_q : prod_q;
        if (mulw_q) begin
            resultSel = {{HALF{signedProd[HALF-1]}}, signedProd[HALF-1:0]};
        end else if (op_q == OP_MUL) begin
            resultSel = signedProd[WIDTH-1:0];
        end else begin
            resultSel = signedProd[2*WIDTH-1:WIDTH];
        end
    end

    assign o_end_valid = endValid_q;
    assign o_result    = endValid_q ? resultSel : '0;

endmodule
